// File: rtl/riscv_core_alu_decode.sv
// rtl/riscv_core_alu_decode.sv - RV64I integer-ALU decode stage with a one-entry valid/ready output register.
// Optional RISCV_ALU_DECODE_STATS_EN adds accepted-legal and accepted-illegal instruction counters.
module riscv_core_alu_decode #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_alu_srcA,
    output logic [XLEN-1:0] o_alu_srcB,
    output logic [3:0]      o_alu_control,
    output logic            o_alu_isword,
    output logic [4:0]      o_rd,
    output logic            o_rd_we,
    output logic            o_illegal
`ifdef RISCV_ALU_DECODE_STATS_EN
    ,
    output logic [31:0]     o_issue_count,
    output logic [31:0]     o_illegal_count
`endif
);

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic            funct7_ok;
    logic            shift_hi_ok;
    logic            word_f3_ok;

    assign opcode      = i_instr[6:0];
    assign funct3      = i_instr[14:12];
    assign funct7      = i_instr[31:25];
    assign imm_i       = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_u       = {{(XLEN-32){i_instr[31]}}, i_instr[31:12], 12'b0};
    assign funct7_ok   = (funct7 == 7'b0000000) ||
                         (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
    // Only the right-shift encoding may carry the arithmetic bit in the upper immediate.
    assign shift_hi_ok = (i_instr[31:26] == 6'b000000) ||
                         (i_instr[31:26] == 6'b010000 && funct3 == 3'b101);
    assign word_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b101);

    logic [XLEN-1:0] dec_src_a;
    logic [XLEN-1:0] dec_src_b;
    logic [3:0]      dec_control;
    logic            dec_isword;
    logic            dec_legal;
    logic [XLEN-1:0] raw_src_a;
    logic [XLEN-1:0] raw_src_b;
    logic [3:0]      raw_control;
    logic            raw_isword;

    always_comb begin
        raw_src_a   = '0;
        raw_src_b   = '0;
        raw_control = ALU_ADD;
        raw_isword  = 1'b0;
        dec_legal   = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_32: begin
                raw_src_a   = i_rs1_data;
                raw_src_b   = i_rs2_data;
                raw_control = alu_op(funct3, funct7[5]);
                raw_isword  = (opcode == OPC_OP_32);
                dec_legal   = funct7_ok && (opcode == OPC_OP || word_f3_ok);
            end
            OPC_OP_IMM: begin
                raw_src_a = i_rs1_data;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    raw_src_b   = {{(XLEN-6){1'b0}}, i_instr[25:20]};
                    raw_control = alu_op(funct3, i_instr[30]);
                    dec_legal   = shift_hi_ok;
                end else begin
                    // Immediate forms never carry the alternate bit, so addi stays add.
                    raw_src_b   = imm_i;
                    raw_control = alu_op(funct3, 1'b0);
                    dec_legal   = 1'b1;
                end
            end
            OPC_OP_IMM32: begin
                raw_src_a  = i_rs1_data;
                raw_isword = 1'b1;
                if (funct3 == 3'b000) begin
                    raw_src_b   = imm_i;
                    raw_control = ALU_ADD;
                    dec_legal   = 1'b1;
                end else begin
                    raw_src_b   = {{(XLEN-5){1'b0}}, i_instr[24:20]};
                    raw_control = alu_op(funct3, i_instr[30]);
                    dec_legal   = word_f3_ok && shift_hi_ok && !i_instr[25];
                end
            end
            OPC_LUI: begin
                raw_src_b = imm_u;
                dec_legal = 1'b1;
            end
            OPC_AUIPC: begin
                raw_src_a = i_pc;
                raw_src_b = imm_u;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_src_a   = dec_legal ? raw_src_a   : '0;
    assign dec_src_b   = dec_legal ? raw_src_b   : '0;
    assign dec_control = dec_legal ? raw_control : ALU_ADD;
    assign dec_isword  = dec_legal && raw_isword;

    logic accept;
    assign o_ready = !i_flush && (!o_valid || i_ready);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_alu_srcA    <= '0;
            o_alu_srcB    <= '0;
            o_alu_control <= ALU_ADD;
            o_alu_isword  <= 1'b0;
            o_rd          <= '0;
            o_rd_we       <= 1'b0;
            o_illegal     <= 1'b0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (accept) begin
            o_valid       <= 1'b1;
            o_alu_srcA    <= dec_src_a;
            o_alu_srcB    <= dec_src_b;
            o_alu_control <= dec_control;
            o_alu_isword  <= dec_isword;
            o_rd          <= dec_legal ? i_instr[11:7] : 5'd0;
            o_rd_we       <= dec_legal && (i_instr[11:7] != 5'd0);
            o_illegal     <= !dec_legal;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

`ifdef RISCV_ALU_DECODE_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_issue_count   <= '0;
            o_illegal_count <= '0;
        end else if (accept) begin
            if (dec_legal) begin
                o_issue_count <= o_issue_count + 32'd1;
            end else begin
                o_illegal_count <= o_illegal_count + 32'd1;
            end
        end
    end
`endif

endmodule
